// File: rtl/fft64_frame_sched.sv
// Shares one fft64 core between channels A and B: round-robin whole-frame grants, tag FIFO, output routing.
// Optional per-channel completed-frame counters are built when FFT64_SCHED_STATS_EN is defined.
module fft64_frame_sched #(
    parameter int W         = 16,
    parameter int TAG_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_a,
    input  logic         req_b,
    input  logic         inv_a,
    input  logic         inv_b,
    input  logic [W-1:0] dat_a_re,
    input  logic [W-1:0] dat_a_im,
    input  logic [W-1:0] dat_b_re,
    input  logic [W-1:0] dat_b_im,
    output logic         rd_a,
    output logic         rd_b,
    output logic         core_valid_in,
    output logic         core_sop_in,
    output logic         core_inv,
    output logic [W-1:0] core_x_re,
    output logic [W-1:0] core_x_im,
    input  logic         core_valid_out,
    input  logic         core_sop_out,
    input  logic [W-1:0] core_y_re,
    input  logic [W-1:0] core_y_im,
    output logic         out_valid,
    output logic         out_sop,
    output logic         out_ch,
    output logic         out_inv,
    output logic [W-1:0] out_re,
    output logic [W-1:0] out_im,
    output logic         tag_err,
    output logic [15:0]  frames_a,
    output logic [15:0]  frames_b
);
    localparam int AW = $clog2(TAG_DEPTH);
    localparam logic [AW:0] FULL_CNT = TAG_DEPTH[AW:0];

    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

    state_t        state;
    logic [5:0]    cnt;
    logic          cur_ch, cur_inv, last;
    logic [1:0]    tag_mem [TAG_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   tag_cnt;

    logic tag_empty, tag_full, tag_pop, room, elig_a, elig_b;
    logic do_grant, grant_ch, grant_inv;

    // In IDLE a full FIFO blocks until the cycle after the pop; at the last
    // sample of a frame a same-cycle pop already counts as free space.
    always_comb begin
        tag_empty = (tag_cnt == '0);
        tag_full  = (tag_cnt == FULL_CNT);
        tag_pop   = core_valid_out & core_sop_out & ~tag_empty;
        room      = (state == IDLE) ? ~tag_full : (~tag_full | tag_pop);
        elig_a    = req_a & room;
        elig_b    = req_b & room;
        grant_ch  = (elig_a & elig_b) ? ~last : elig_b;
        grant_inv = grant_ch ? inv_b : inv_a;
        do_grant  = ((state == IDLE) || (cnt == 6'd63)) & (elig_a | elig_b);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            cur_ch        <= 1'b0;
            cur_inv       <= 1'b0;
            last          <= 1'b1;
            rd_a          <= 1'b0;
            rd_b          <= 1'b0;
            core_valid_in <= 1'b0;
            core_sop_in   <= 1'b0;
            core_inv      <= 1'b0;
            core_x_re     <= '0;
            core_x_im     <= '0;
        end else begin
            if (do_grant) begin
                state   <= STREAM;
                cnt     <= '0;
                cur_ch  <= grant_ch;
                cur_inv <= grant_inv;
                last    <= grant_ch;
                rd_a    <= ~grant_ch;
                rd_b    <= grant_ch;
            end else if (state == STREAM) begin
                cnt <= cnt + 6'd1;
                if (cnt == 6'd63) begin
                    state <= IDLE;
                    rd_a  <= 1'b0;
                    rd_b  <= 1'b0;
                end
            end
            core_valid_in <= rd_a | rd_b;
            core_sop_in   <= (state == STREAM) && (cnt == 6'd0);
            core_inv      <= cur_inv;
            core_x_re     <= cur_ch ? dat_b_re : dat_a_re;
            core_x_im     <= cur_ch ? dat_b_im : dat_a_im;
        end
    end

    always_ff @(posedge clk) begin
        if (do_grant && !rst) tag_mem[wr_ptr] <= {grant_ch, grant_inv};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            tag_cnt   <= '0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_ch    <= 1'b0;
            out_inv   <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            tag_err   <= 1'b0;
        end else begin
            if (do_grant) wr_ptr <= wr_ptr + 1'b1;
            if (tag_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_grant, tag_pop})
                2'b10:   tag_cnt <= tag_cnt + 1'b1;
                2'b01:   tag_cnt <= tag_cnt - 1'b1;
                default: tag_cnt <= tag_cnt;
            endcase
            out_valid <= core_valid_out;
            out_sop   <= core_valid_out & core_sop_out;
            out_re    <= core_y_re;
            out_im    <= core_y_im;
            // A frame with no matching tag is reported and routed to channel A.
            if (core_valid_out & core_sop_out) begin
                if (tag_empty) begin
                    tag_err <= 1'b1;
                    out_ch  <= 1'b0;
                    out_inv <= 1'b0;
                end else begin
                    {out_ch, out_inv} <= tag_mem[rd_ptr];
                end
            end
        end
    end

`ifdef FFT64_SCHED_STATS_EN
    logic [5:0] ocnt;

    // ocnt counts samples already seen in the current output frame; 0 = none.
    always_ff @(posedge clk) begin
        if (rst) begin
            ocnt     <= '0;
            frames_a <= '0;
            frames_b <= '0;
        end else if (out_valid) begin
            if (out_sop) begin
                ocnt <= 6'd1;
            end else if (ocnt != 6'd0) begin
                if (ocnt == 6'd63) begin
                    ocnt <= '0;
                    if (out_ch) frames_b <= frames_b + 16'd1;
                    else        frames_a <= frames_a + 16'd1;
                end else begin
                    ocnt <= ocnt + 6'd1;
                end
            end
        end
    end
`else
    assign frames_a = '0;
    assign frames_b = '0;
`endif

endmodule

// File: tb/tb_fft64_frame_sched.sv
// Self-checking bench for fft64_frame_sched: FWFT buffer models, loopback core model,
// frame-level round-robin reference and per-sample scoreboards.
module tb_fft64_frame_sched;
    localparam int W  = 16;
    localparam int SW = 2 * W;
    localparam int TD = 2;
`ifdef FFT64_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_a = 1'b0, req_b = 1'b0, inv_a = 1'b0, inv_b = 1'b0;
    logic [W-1:0] dat_a_re = '0, dat_a_im = '0, dat_b_re = '0, dat_b_im = '0;
    logic         rd_a, rd_b, core_valid_in, core_sop_in, core_inv;
    logic [W-1:0] core_x_re, core_x_im;
    logic         core_valid_out = 1'b0, core_sop_out = 1'b0;
    logic [W-1:0] core_y_re = '0, core_y_im = '0;
    logic         out_valid, out_sop, out_ch, out_inv, tag_err;
    logic [W-1:0] out_re, out_im;
    logic [15:0]  frames_a, frames_b;

    fft64_frame_sched #(.W(W), .TAG_DEPTH(TD)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b), .inv_a(inv_a), .inv_b(inv_b),
        .dat_a_re(dat_a_re), .dat_a_im(dat_a_im), .dat_b_re(dat_b_re), .dat_b_im(dat_b_im),
        .rd_a(rd_a), .rd_b(rd_b),
        .core_valid_in(core_valid_in), .core_sop_in(core_sop_in), .core_inv(core_inv),
        .core_x_re(core_x_re), .core_x_im(core_x_im),
        .core_valid_out(core_valid_out), .core_sop_out(core_sop_out),
        .core_y_re(core_y_re), .core_y_im(core_y_im),
        .out_valid(out_valid), .out_sop(out_sop), .out_ch(out_ch), .out_inv(out_inv),
        .out_re(out_re), .out_im(out_im), .tag_err(tag_err),
        .frames_a(frames_a), .frames_b(frames_b)
    );

    // Clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Channel buffers, reference state and scoreboards
    logic [SW-1:0] buf_a[$], buf_b[$];
    logic [SW-1:0] exp_a[$], exp_b[$];
    int            frames_left_a, frames_left_b;
    logic [SW-1:0] exp_q[$];
    logic          exp_inv;
    logic [1:0]    exp_tag_q[$];
    logic          m_last, cur_ech, cur_einv, m_tag_err;
    logic [SW:0]   core_q[$];
    logic          core_run = 1'b0, force_sop = 1'b0;
    logic          drv_v, drv_sop;
    logic [SW-1:0] drv_y;
    logic          pend_a, pend_b;
    int            cyc = 0;
    int            n_rd_a, n_rd_b, n_v, first_rd_a, last_rd_a, first_rd_b, first_v, last_v;
    int            sop_cyc[$];

    task automatic clear_trackers();
        n_rd_a = 0; n_rd_b = 0; n_v = 0;
        first_rd_a = -1; last_rd_a = -1; first_rd_b = -1; first_v = -1; last_v = -1;
        sop_cyc.delete();
    endtask

    task automatic drive_inputs();
        logic [SW-1:0] ha, hb;
        ha = (buf_a.size() > 0) ? buf_a[0] : '0;
        hb = (buf_b.size() > 0) ? buf_b[0] : '0;
        req_a    = (buf_a.size() >= 64);
        req_b    = (buf_b.size() >= 64);
        dat_a_re = ha[SW-1:W]; dat_a_im = ha[W-1:0];
        dat_b_re = hb[SW-1:W]; dat_b_im = hb[W-1:0];
    endtask

    task automatic load_frame(input bit ch);
        logic [SW-1:0] s;
        for (int i = 0; i < 64; i++) begin
            s = SW'({$urandom(), $urandom()});
            if (ch) begin buf_b.push_back(s); exp_b.push_back(s); end
            else    begin buf_a.push_back(s); exp_a.push_back(s); end
        end
        if (ch) frames_left_b++; else frames_left_a++;
        drive_inputs();
    endtask

    task automatic flush_models();
        buf_a.delete(); buf_b.delete(); exp_a.delete(); exp_b.delete();
        exp_q.delete(); exp_tag_q.delete(); core_q.delete();
        frames_left_a = 0; frames_left_b = 0;
        m_last = 1'b1; cur_ech = 1'b0; cur_einv = 1'b0; m_tag_err = 1'b0; exp_inv = 1'b0;
        pend_a = 1'b0; pend_b = 1'b0; force_sop = 1'b0;
        drv_v = 1'b0; drv_sop = 1'b0; drv_y = '0;
        core_valid_out = 1'b0; core_sop_out = 1'b0; core_y_re = '0; core_y_im = '0;
        drive_inputs();
    endtask

    // Reset: asserted from the current negedge, outputs checked for three cycles
    task automatic apply_reset();
        rst = 1'b1;
        flush_models();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ctrl", {rd_a, rd_b, core_valid_in, core_sop_in, core_inv,
                             out_valid, out_sop, out_ch, out_inv, tag_err}, 0);
            chk("rst_data", {core_x_re, core_x_im, out_re, out_im}, 0);
            chk("rst_frames", {frames_a, frames_b}, 0);
        end
        rst = 1'b0;
    endtask

    // One clock: observe at negedge, update buffers and core model, drive inputs.
    task automatic step();
        logic          ch;
        logic [SW-1:0] e;
        logic [SW:0]   c;
        @(negedge clk);
        cyc++;
        if (pend_a && buf_a.size() > 0) void'(buf_a.pop_front());
        if (pend_b && buf_b.size() > 0) void'(buf_b.pop_front());

        if (rd_a) begin n_rd_a++; if (first_rd_a < 0) first_rd_a = cyc; last_rd_a = cyc; end
        if (rd_b) begin n_rd_b++; if (first_rd_b < 0) first_rd_b = cyc; end
        chk("rd_onehot", rd_a & rd_b, 0);
        chk("sop_wo_valid", core_sop_in & ~core_valid_in, 0);

        if (core_valid_in) begin
            n_v++; if (first_v < 0) first_v = cyc; last_v = cyc;
            if (core_sop_in) begin
                sop_cyc.push_back(cyc);
                chk("frame_len", exp_q.size(), 0);
                exp_q.delete();
                if (frames_left_a == 0 && frames_left_b == 0) begin
                    chk("spurious_sop", core_sop_in, 0);
                end else begin
                    if (frames_left_a > 0 && frames_left_b > 0) ch = ~m_last;
                    else ch = (frames_left_a == 0);
                    m_last = ch;
                    for (int i = 0; i < 64; i++)
                        exp_q.push_back(ch ? exp_b.pop_front() : exp_a.pop_front());
                    if (ch) frames_left_b--; else frames_left_a--;
                    exp_inv = ch ? inv_b : inv_a;
                    exp_tag_q.push_back({ch, exp_inv});
                end
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("core_x", {core_x_re, core_x_im}, e);
                chk("core_inv", core_inv, exp_inv);
            end else begin
                chk("stray_valid", core_valid_in, 0);
            end
            core_q.push_back({core_sop_in, core_x_re, core_x_im});
        end else if (exp_q.size() > 0) begin
            chk("frame_gap", core_valid_in, 1);
        end

        chk("out_valid", out_valid, drv_v);
        chk("out_sop", out_sop, drv_v & drv_sop);
        if (drv_v & drv_sop) begin
            if (exp_tag_q.size() > 0) {cur_ech, cur_einv} = exp_tag_q.pop_front();
            else begin cur_ech = 1'b0; cur_einv = 1'b0; m_tag_err = 1'b1; end
        end
        if (drv_v) begin
            chk("out_data", {out_re, out_im}, drv_y);
            chk("out_ch", out_ch, cur_ech);
            chk("out_inv", out_inv, cur_einv);
        end
        chk("tag_err", tag_err, m_tag_err);

        if (force_sop) begin
            drv_v = 1'b1; drv_sop = 1'b1; drv_y = SW'($urandom()); force_sop = 1'b0;
        end else if (core_run && core_q.size() > 0) begin
            c = core_q.pop_front();
            drv_v = 1'b1; drv_sop = c[SW]; drv_y = c[SW-1:0];
        end else begin
            drv_v = 1'b0; drv_sop = 1'b0; drv_y = SW'($urandom());
        end
        core_valid_out = drv_v; core_sop_out = drv_sop;
        {core_y_re, core_y_im} = drv_y;
        pend_a = rd_a; pend_b = rd_b;
        drive_inputs();
    endtask

    initial begin
        int t0, p;

        // Power-on reset
        apply_reset();
        repeat (2) step();

        // Single A frame, inverse
        core_run = 1'b1; inv_a = 1'b1; inv_b = 1'b0;
        clear_trackers(); t0 = cyc;
        load_frame(1'b0);
        repeat (80) step();
        chk("s1_rd_first", first_rd_a, t0 + 1);
        chk("s1_rd_last", last_rd_a, t0 + 64);
        chk("s1_rd_count", n_rd_a, 64);
        chk("s1_rd_b_count", n_rd_b, 0);
        chk("s1_v_first", first_v, t0 + 2);
        chk("s1_v_last", last_v, t0 + 65);
        chk("s1_sop_count", sop_cyc.size(), 1);
        if (sop_cyc.size() > 0) chk("s1_sop_cycle", sop_cyc[0], t0 + 2);

        // Both channels, four back-to-back frames A,B,A,B
        apply_reset();
        repeat (2) step();
        core_run = 1'b1; inv_a = 1'b0; inv_b = 1'b1;
        clear_trackers(); t0 = cyc;
        load_frame(1'b0); load_frame(1'b1); load_frame(1'b0); load_frame(1'b1);
        repeat (300) step();
        chk("s2_v_count", n_v, 256);
        chk("s2_v_first", first_v, t0 + 2);
        chk("s2_v_last", last_v, t0 + 257);
        chk("s2_sop_count", sop_cyc.size(), 4);
        for (int k = 0; k < sop_cyc.size() && k < 4; k++)
            chk("s2_sop_cycle", sop_cyc[k], t0 + 2 + 64 * k);
        chk("s2_tags_drained", exp_tag_q.size(), 0);
        chk("s2_frames_a", frames_a, STATS ? 2 : 0);
        chk("s2_frames_b", frames_b, STATS ? 2 : 0);

        // Tag FIFO full with the core output held idle
        apply_reset();
        repeat (2) step();
        core_run = 1'b0; inv_a = 1'($urandom_range(0, 1));
        clear_trackers();
        load_frame(1'b0); load_frame(1'b0); load_frame(1'b0);
        repeat (200) step();
        chk("s3_frames_issued", sop_cyc.size(), 2);
        chk("s3_idle_rd", rd_a | rd_b, 0);
        core_run = 1'b1;
        step();
        p = cyc;
        clear_trackers();
        repeat (5) step();
        chk("s3_regrant_cycle", first_rd_a, p + 2);
        repeat (250) step();
        chk("s3_rd_count", n_rd_a, 64);
        chk("s3_tags_drained", exp_tag_q.size(), 0);

        // Reset in the middle of an A frame, then a B frame and an orphan sop
        apply_reset();
        repeat (2) step();
        core_run = 1'b1; inv_a = 1'($urandom_range(0, 1)); inv_b = 1'b1;
        load_frame(1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            if (rd_a) break;
        end
        chk("s5_rd_started", rd_a, 1);
        repeat (30) step();
        apply_reset();
        clear_trackers();
        load_frame(1'b1);
        repeat (150) step();
        chk("s5_rd_b_count", n_rd_b, 64);
        chk("s5_rd_a_count", n_rd_a, 0);
        chk("s5_sop_count", sop_cyc.size(), 1);
        chk("s5_tags_drained", exp_tag_q.size(), 0);
        force_sop = 1'b1;
        step();
        step();
        chk("s5_orphan_err", tag_err, 1);
        chk("s5_orphan_ch", {out_ch, out_inv}, 0);
        repeat (3) step();
        chk("s5_err_sticky", tag_err, 1);

        // Frame counters: 3 A and 2 B frames through the loopback core
        apply_reset();
        repeat (2) step();
        core_run = 1'b1;
        inv_a = 1'($urandom_range(0, 1)); inv_b = 1'($urandom_range(0, 1));
        clear_trackers();
        for (int i = 0; i < 3; i++) load_frame(1'b0);
        for (int i = 0; i < 2; i++) load_frame(1'b1);
        repeat (420) step();
        chk("s6_sop_count", sop_cyc.size(), 5);
        chk("s6_tags_drained", exp_tag_q.size(), 0);
        chk("s6_frames_a", frames_a, STATS ? 3 : 0);
        chk("s6_frames_b", frames_b, STATS ? 2 : 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
